// File: rtl/gp_regfile_v2.sv
// gp_regfile_v2: parametrised general-purpose register file.
// Combinational read ports with optional write-to-read bypass and an
// optional hardwired-zero entry 0. A hardware sequencer zeroes every
// entry after reset or on ClrReq; Busy is high while it runs.
module gp_regfile_v2 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     ClrReq,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        AddrRd,
  input  logic [DATA_W-1:0]        WrData,
  input  logic [NUM_RD*ADDR_W-1:0] AddrRs,
  output logic [NUM_RD*DATA_W-1:0] RdData,
  output logic                     Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            stateR;
  logic [ADDR_W-1:0] clrCntR;
  logic              busyR;
  logic [DATA_W-1:0] memR [DEPTH];

  logic              wrEnS;
  logic [ADDR_W-1:0] wrAddrS;
  logic [DATA_W-1:0] wrDataS;
  logic [NUM_RD*DATA_W-1:0] rdDataS;

  // Clear sequencer: CLEAR walks ClrCnt over every entry, RUN accepts ClrReq.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stateR  <= CLEAR;
      clrCntR <= {ADDR_W{1'b0}};
      busyR   <= 1'b1;
    end else begin
      case (stateR)
        CLEAR: begin
          clrCntR <= clrCntR + ADDR_W'(1);
          if (clrCntR == {ADDR_W{1'b1}}) begin
            // Last entry cleared; ClrCnt wraps to 0 here.
            stateR <= RUN;
            busyR  <= 1'b0;
          end
        end
        RUN: begin
          if (ClrReq) begin
            stateR  <= CLEAR;
            clrCntR <= {ADDR_W{1'b0}};
            busyR   <= 1'b1;
          end
        end
        default: begin
          stateR  <= CLEAR;
          clrCntR <= {ADDR_W{1'b0}};
          busyR   <= 1'b1;
        end
      endcase
    end
  end

  // Select the single array write per edge: clear entry, user write, or none.
  always_comb begin
    wrEnS   = 1'b0;
    wrAddrS = clrCntR;
    wrDataS = {DATA_W{1'b0}};
    if (Rst) begin
      wrEnS = 1'b0;
    end else if (stateR == CLEAR) begin
      wrEnS   = 1'b1;
      wrAddrS = clrCntR;
      wrDataS = {DATA_W{1'b0}};
    end else if (ClrReq) begin
      // Clear request wins over a write in the same cycle.
      wrEnS = 1'b0;
    end else if (RegWrite && !((ZERO_REG != 0) && (AddrRd == {ADDR_W{1'b0}}))) begin
      wrEnS   = 1'b1;
      wrAddrS = AddrRd;
      wrDataS = WrData;
    end else begin
      wrEnS = 1'b0;
    end
  end

  // Storage array update.
  always_ff @(posedge Clk) begin
    if (wrEnS) begin
      memR[wrAddrS] <= wrDataS;
    end
  end

  // Read ports: zero while busy, hardwired x0, then bypass, then array.
  always_comb begin
    rdDataS = {(NUM_RD*DATA_W){1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (busyR) begin
        rdDataS[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((ZERO_REG != 0) && (AddrRs[k*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
        rdDataS[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && RegWrite &&
                   (AddrRd == AddrRs[k*ADDR_W +: ADDR_W]) &&
                   ((AddrRd != {ADDR_W{1'b0}}) || (ZERO_REG == 0))) begin
        rdDataS[k*DATA_W +: DATA_W] = WrData;
      end else begin
        rdDataS[k*DATA_W +: DATA_W] = memR[AddrRs[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign RdData = rdDataS;
  assign Busy   = busyR;

endmodule

// File: tb/tb_gp_regfile_v2.sv
// Directed self-checking bench for gp_regfile_v2. Instance A uses the
// defaults, C shares A's stimulus with BYPASS=0, and B is a 4-port,
// 8-entry configuration with its own write/read stimulus.
module tb_gp_regfile_v2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ClrReq;
  logic        RegWrite;
  logic [4:0]  AddrRd;
  logic [31:0] WrData;
  logic [9:0]  AddrRs;
  logic [63:0] rdDataA;
  logic [63:0] rdDataC;
  logic        busyA;
  logic        busyC;

  logic        clrReqB;
  logic        regWriteB;
  logic [2:0]  addrRdB;
  logic [31:0] wrDataB;
  logic [11:0] addrRsB;
  logic [127:0] rdDataB;
  logic        busyB;

  int assertCnt = 0;
  int failCnt   = 0;

  always #5 Clk = ~Clk;

  gp_regfile_v2 dutA (
    .Clk(Clk), .Rst(Rst), .ClrReq(ClrReq), .RegWrite(RegWrite),
    .AddrRd(AddrRd), .WrData(WrData), .AddrRs(AddrRs),
    .RdData(rdDataA), .Busy(busyA)
  );

  gp_regfile_v2 #(.BYPASS(0)) dutC (
    .Clk(Clk), .Rst(Rst), .ClrReq(ClrReq), .RegWrite(RegWrite),
    .AddrRd(AddrRd), .WrData(WrData), .AddrRs(AddrRs),
    .RdData(rdDataC), .Busy(busyC)
  );

  gp_regfile_v2 #(.NUM_RD(4), .ADDR_W(3)) dutB (
    .Clk(Clk), .Rst(Rst), .ClrReq(clrReqB), .RegWrite(regWriteB),
    .AddrRd(addrRdB), .WrData(wrDataB), .AddrRs(addrRsB),
    .RdData(rdDataB), .Busy(busyB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Step 32 edges after a clear starts, checking Busy and forced-zero reads.
  task automatic runClear(input string tag, input bit withB);
    for (int i = 1; i <= 32; i++) begin
      tick();
      checkVal({tag, "_busyA"}, {31'd0, busyA}, (i < 32) ? 32'd1 : 32'd0);
      if (i < 32) begin
        checkVal({tag, "_rdA0"}, rdDataA[31:0], 32'd0);
      end
      if (withB) begin
        checkVal({tag, "_busyB"}, {31'd0, busyB}, (i < 8) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // Read every entry 1..31 on port 0 of A and C and expect zero.
  task automatic checkAllZero(input string tag);
    for (int a = 1; a < 32; a++) begin
      AddrRs = {5'd0, 5'(a)};
      #1;
      checkVal({tag, "_A"}, rdDataA[31:0], 32'd0);
      checkVal({tag, "_C"}, rdDataC[31:0], 32'd0);
    end
  endtask

  initial begin
    Rst = 1'b1; ClrReq = 1'b0; RegWrite = 1'b0; AddrRd = 5'd0;
    WrData = 32'd0; AddrRs = {5'd5, 5'd5};
    clrReqB = 1'b0; regWriteB = 1'b0; addrRdB = 3'd0; wrDataB = 32'd0;
    addrRsB = 12'd0;

    // Reset held for two cycles, then a full clear sequence.
    tick(); tick();
    checkVal("rst_busyA", {31'd0, busyA}, 32'd1);
    checkVal("rst_busyB", {31'd0, busyB}, 32'd1);
    checkVal("rst_rdA0", rdDataA[31:0], 32'd0);
    checkVal("rst_rdA1", rdDataA[63:32], 32'd0);
    Rst = 1'b0;
    runClear("clr_rst", 1'b1);
    checkAllZero("rst_zero");

    // Multi-port config: write 3 = 0xA5, read {3,3,0,2}.
    regWriteB = 1'b1; addrRdB = 3'd3; wrDataB = 32'h0000_00A5;
    addrRsB = {3'd2, 3'd0, 3'd3, 3'd3};
    tick();
    regWriteB = 1'b0;
    #1;
    checkVal("mp_p0", rdDataB[31:0],   32'h0000_00A5);
    checkVal("mp_p1", rdDataB[63:32],  32'h0000_00A5);
    checkVal("mp_p2", rdDataB[95:64],  32'd0);
    checkVal("mp_p3", rdDataB[127:96], 32'd0);

    // Write with same-cycle read of the target on both ports.
    RegWrite = 1'b1; AddrRd = 5'd5; WrData = 32'hDEAD_BEEF; AddrRs = {5'd5, 5'd5};
    #1;
    checkVal("byp_A0", rdDataA[31:0],  32'hDEAD_BEEF);
    checkVal("byp_A1", rdDataA[63:32], 32'hDEAD_BEEF);
    checkVal("nobyp_C0", rdDataC[31:0], 32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    checkVal("wr_A0", rdDataA[31:0], 32'hDEAD_BEEF);
    checkVal("wr_C0", rdDataC[31:0], 32'hDEAD_BEEF);

    // x0 protection.
    RegWrite = 1'b1; AddrRd = 5'd0; WrData = 32'h1234_5678; AddrRs = {5'd0, 5'd0};
    #1;
    checkVal("x0_same_A0", rdDataA[31:0],  32'd0);
    checkVal("x0_same_A1", rdDataA[63:32], 32'd0);
    checkVal("x0_same_C0", rdDataC[31:0],  32'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    checkVal("x0_next_A0", rdDataA[31:0],  32'd0);
    checkVal("x0_next_A1", rdDataA[63:32], 32'd0);

    // Fill 1..31 with own index.
    for (int a = 1; a < 32; a++) begin
      RegWrite = 1'b1; AddrRd = 5'(a); WrData = 32'(a);
      tick();
    end
    RegWrite = 1'b0;
    AddrRs = {5'd31, 5'd9};
    #1;
    checkVal("fill_9",  rdDataA[31:0],  32'd9);
    checkVal("fill_31", rdDataA[63:32], 32'd31);
    checkVal("fill_C9", rdDataC[31:0],  32'd9);

    // Clear request together with a write to entry 7.
    ClrReq = 1'b1; RegWrite = 1'b1; AddrRd = 5'd7; WrData = 32'h0000_00FF;
    AddrRs = {5'd7, 5'd7};
    tick();
    ClrReq = 1'b0; RegWrite = 1'b0;
    #1;
    checkVal("clrq_busy", {31'd0, busyA}, 32'd1);
    checkVal("clrq_rd1",  rdDataA[63:32], 32'd0);
    runClear("clr_req", 1'b0);
    AddrRs = {5'd0, 5'd7};
    #1;
    checkVal("clrq_e7", rdDataA[31:0], 32'd0);
    checkAllZero("clrq_zero");

    // Reset at clear cycle 20 restarts the full sequence.
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
    end
    checkVal("mid_busy", {31'd0, busyA}, 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    runClear("clr_mid", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
